pc_fetch_sequencer: RTL and testbench

//  Fetch-stage program-counter sequencer: holds the 64-bit PC, issues fetch

---
 rtl/pc_fetch_sequencer.sv | 91 +++++++++
 tb/tb_pc_fetch_sequencer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC sequencer: owns the program counter, issues fetch requests over
// valid/ready, steps the PC through an external incrementer and tracks redirects.
module pc_fetch_sequencer #(
    parameter logic [63:0] RESET_VECTOR = 64'h0000_0000_0000_0000,
    parameter logic [4:0]  INC          = 5'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [63:0] fetch_pc,
    output logic [63:0] inc_a,
    output logic [4:0]  inc_b,
    input  logic [64:0] inc_sum,
    output logic        pc_overflow,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        ISSUE  = 2'd1,
        BUBBLE = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        overflow_q, overflow_d;
    logic [31:0] count_q, count_d;
    logic        accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            overflow_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        accept     = (state_q == ISSUE) && fetch_ready;

        case (state_q)
            BOOT:   state_d = ISSUE;
            BUBBLE: state_d = ISSUE;
            ISSUE: begin
                if (accept) begin
                    pc_d = inc_sum[63:0];
                    // Carry-out means the PC wrapped past the top of the address space.
                    if (inc_sum[64]) begin
                        state_d    = FAULT;
                        overflow_d = 1'b1;
                    end
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
        endcase

        if (accept) begin
            count_d = count_q + 32'd1;
        end

        // A redirect overrides the sequential step, but an accepted request still counts.
        if (redirect_valid) begin
            pc_d       = {redirect_pc[63:2], 2'b00};
            state_d    = BUBBLE;
            overflow_d = (state_q == FAULT) ? 1'b0 : overflow_q;
        end
    end

    assign fetch_valid = (state_q == ISSUE);
    assign fetch_pc    = pc_q;
    assign inc_a       = pc_q;
    assign inc_b       = INC;
    assign pc_overflow = overflow_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a request-level model of the fetch stream.
module tb_pc_fetch_sequencer;

    localparam logic [63:0] RV = 64'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        fetch_ready = 1'b0;
    logic        fetch_valid;
    logic [63:0] fetch_pc;
    logic [63:0] inc_a;
    logic [4:0]  inc_b;
    logic [64:0] inc_sum;
    logic        pc_overflow;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    // Reference model: what the fetch stream looks like from outside.
    logic [63:0] m_pc;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    // Downstream incrementer: purely combinational 65-bit sum.
    assign inc_sum = {1'b0, inc_a} + {60'd0, inc_b};

    pc_fetch_sequencer #(.RESET_VECTOR(RV), .INC(5'd4)) dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_pc(fetch_pc),
        .inc_a(inc_a),
        .inc_b(inc_b),
        .inc_sum(inc_sum),
        .pc_overflow(pc_overflow),
        .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic rv, input logic [63:0] rpc,
                                input logic rdy);
        logic        acc;
        logic [64:0] wide;
        if (r) begin
            m_pc    = RV;
            m_valid = 1'b0;
            m_fault = 1'b0;
            m_count = 32'd0;
        end else begin
            acc = m_valid && rdy;
            if (acc) m_count = m_count + 32'd1;
            if (rv) begin
                m_pc    = rpc & ~64'd3;
                m_valid = 1'b0;
                m_fault = 1'b0;
            end else if (acc) begin
                wide = {1'b0, m_pc} + 65'd4;
                m_pc = wide[63:0];
                if (wide[64]) begin
                    m_fault = 1'b1;
                    m_valid = 1'b0;
                end
            end else if (!m_valid && !m_fault) begin
                m_valid = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic rv, input logic [63:0] rpc, input logic rdy);
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        fetch_ready    = rdy;
        @(posedge clk);
        model_update(r, rv, rpc, rdy);
        #1;
        chk("valid",    {64'd0, fetch_valid}, {64'd0, m_valid});
        chk("pc",       {1'b0, fetch_pc},     {1'b0, m_pc});
        chk("inc_a",    {1'b0, inc_a},        {1'b0, m_pc});
        chk("inc_b",    {60'd0, inc_b},       65'd4);
        chk("overflow", {64'd0, pc_overflow}, {64'd0, m_fault});
        chk("count",    {33'd0, fetch_count}, {33'd0, m_count});
        $display("step rst=%0d redir=%0d rpc=%h rdy=%0d -> valid=%0d pc=%h ovf=%0d cnt=%0d",
                 r, rv, rpc, rdy, fetch_valid, fetch_pc, pc_overflow, fetch_count);
    endtask

    initial begin
        logic        r, rv, rdy;
        logic [63:0] rpc;

        // Reset then free-running fetch from the reset vector.
        step(1'b1, 1'b0, 64'h0, 1'b1);
        chk("reset_valid", {64'd0, fetch_valid}, 65'd0);
        chk("reset_count", {33'd0, fetch_count}, 65'd0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("boot_pc0", {1'b0, fetch_pc}, 65'h0);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("seq_pcC", {1'b0, fetch_pc}, 65'hC);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("seq_count4", {33'd0, fetch_count}, 65'd4);

        // Stall at 0x100: PC and valid must hold until accepted.
        step(1'b0, 1'b1, 64'h100, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("stall_pc", {1'b0, fetch_pc}, 65'h100);
        chk("stall_valid", {64'd0, fetch_valid}, 65'd1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("after_stall_pc", {1'b0, fetch_pc}, 65'h104);

        // Redirect colliding with an accept.
        step(1'b0, 1'b1, 64'h2003, 1'b1);
        chk("redir_bubble", {64'd0, fetch_valid}, 65'd0);
        chk("redir_count", {33'd0, fetch_count}, 65'd6);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("redir_pc", {1'b0, fetch_pc}, 65'h2000);

        // Wrap past 2^64 into the fault state, then recover by redirect.
        step(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("wrap_ovf", {64'd0, pc_overflow}, 65'd1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("fault_valid", {64'd0, fetch_valid}, 65'd0);
        step(1'b0, 1'b1, 64'h40, 1'b1);
        chk("fault_clear", {64'd0, pc_overflow}, 65'd0);
        step(1'b0, 1'b0, 64'h0, 1'b0);
        chk("recover_pc", {1'b0, fetch_pc}, 65'h40);

        // Reset beats a simultaneous redirect.
        step(1'b1, 1'b1, 64'h5550, 1'b0);
        chk("rst_over_redir", {1'b0, fetch_pc}, {1'b0, RV});
        step(1'b0, 1'b0, 64'h0, 1'b0);

        // Counter wrap via backdoor preload.
        force dut.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.count_q;
        m_count = 32'hFFFF_FFFE;
        step(1'b0, 1'b0, 64'h0, 1'b1);
        step(1'b0, 1'b0, 64'h0, 1'b1);
        chk("count_wrap", {33'd0, fetch_count}, 65'd0);

        // Random traffic, with some redirects aimed near the top of memory.
        for (int i = 0; i < 400; i++) begin
            r   = ($urandom_range(0, 99) < 2);
            rv  = ($urandom_range(0, 99) < 8);
            rdy = ($urandom_range(0, 99) < 70);
            rpc = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFC0 | {58'd0, rpc[5:0]};
            step(r, rv, rpc, rdy);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
